seg_scan_controller: RTL and testbench

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_scan_controller_pkg.sv | 58 +++++
 rtl/seg_scan_controller_glyph_rom.sv | 17 +
 rtl/seg_scan_controller.sv | 123 ++++++++++++
 tb/tb_seg_scan_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_controller_pkg.sv
// Shared definitions for the 4-digit seven-segment scan controller.
// Holds the digit code space, the active-low glyph table, the two-state
// scan enum, active-low anode patterns and the frame type.
package seg_scan_controller_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int CODE_W     = 6;
  localparam int SEG_W      = 7;

  localparam logic [CODE_W-1:0] CODE_OFF  = 6'd16;
  localparam logic [CODE_W-1:0] CODE_DASH = 6'd17;

  // Segment order {a,b,c,d,e,f,g}, bit 6 = a, 0 = lit.
  localparam logic [SEG_W-1:0] GLYPH_OFF  = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_DASH = 7'b1111110;

  // Hex glyphs, entry 0 in the low slice.
  localparam logic [15:0][SEG_W-1:0] GLYPH_HEX = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic {BLANK, DRIVE} state_t;

  localparam logic [NUM_DIGITS-1:0] AN_NONE = 4'b1111;
  localparam logic [NUM_DIGITS-1:0] AN_D0   = 4'b1110;
  localparam logic [NUM_DIGITS-1:0] AN_D1   = 4'b1101;
  localparam logic [NUM_DIGITS-1:0] AN_D2   = 4'b1011;
  localparam logic [NUM_DIGITS-1:0] AN_D3   = 4'b0111;

  typedef logic [NUM_DIGITS-1:0][CODE_W-1:0] frame_t;

  localparam frame_t FRAME_OFF = {NUM_DIGITS{CODE_OFF}};

  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    return AN_D0;
      2'd1:    return AN_D1;
      2'd2:    return AN_D2;
      default: return AN_D3;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_controller_glyph_rom.sv
// seg_glyph_rom: combinational 6-bit digit code to 7-bit active-low glyph.
//   i_code  : digit code (0-15 hex, 16 off, 17 dash, 18-63 off)
//   o_glyph : active-low segments {a..g}
module seg_glyph_rom
  import seg_scan_controller_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [SEG_W-1:0]  o_glyph
);

  always_comb begin
    o_glyph = GLYPH_OFF;
    if (i_code < 6'd16)           o_glyph = GLYPH_HEX[i_code[3:0]];
    else if (i_code == CODE_DASH) o_glyph = GLYPH_DASH;
  end

endmodule

// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed 4-digit seven-segment driver with
// per-slot blanking and a tear-free double-buffered frame load.
//   clk, rst_n   : clock, synchronous active-low reset
//   enable       : scan enable; low holds the display dark at digit0/BLANK
//   load_valid   : new frame offered on digits
//   load_ready   : shadow buffer free (no frame pending)
//   digits[23:0] : four 6-bit codes, [5:0] = digit0 (rightmost)
//   seg[6:0]     : active-low segments, bit 6 = a
//   an[3:0]      : active-low anodes, an[0] = digit0
//   frame_done   : one-clock pulse after the last clock of each digit3 slot
module seg_scan_controller
  import seg_scan_controller_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [NUM_DIGITS*CODE_W-1:0]   digits,
  output logic [SEG_W-1:0]               seg,
  output logic [NUM_DIGITS-1:0]          an,
  output logic                           frame_done
);

  localparam int               CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            r_idx;
  state_t                r_state, w_state_nxt;
  frame_t                r_active, r_shadow;
  logic                  r_pending;
  logic [NUM_DIGITS-1:0] r_an, w_an_nxt;
  logic [SEG_W-1:0]      r_seg, w_seg_nxt;
  logic                  r_frame_done;

  logic                  w_slot_end, w_boundary, w_accept;
  logic [CODE_W-1:0]     w_code;
  logic [SEG_W-1:0]      w_glyph;

  assign w_slot_end = (r_cnt == CNT_MAX);
  // Frame boundary only exists while scanning; a disabled display never swaps.
  assign w_boundary = enable && w_slot_end && (r_idx == 2'd3);
  assign w_accept   = load_valid && !r_pending;
  assign w_code     = r_active[r_idx];

  assign load_ready = !r_pending;
  assign an         = r_an;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;

  seg_glyph_rom u_rom (
    .i_code  (w_code),
    .o_glyph (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= BLANK;
    else        r_state <= w_state_nxt;
  end

  // State tracks the counter: BLANK covers counts 0..BLANK_CYCLES-1.
  always_comb begin
    w_state_nxt = r_state;
    w_an_nxt    = AN_NONE;
    w_seg_nxt   = GLYPH_OFF;
    case (r_state)
      BLANK: if (r_cnt == BLANK_LAST) w_state_nxt = DRIVE;
      DRIVE: begin
        w_an_nxt  = anode_sel(r_idx);
        w_seg_nxt = w_glyph;
        if (w_slot_end) w_state_nxt = BLANK;
      end
      default: w_state_nxt = BLANK;
    endcase
    if (!enable) begin
      w_state_nxt = BLANK;
      w_an_nxt    = AN_NONE;
      w_seg_nxt   = GLYPH_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_pending    <= 1'b0;
      r_active     <= FRAME_OFF;
      r_shadow     <= FRAME_OFF;
      r_an         <= AN_NONE;
      r_seg        <= GLYPH_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_an         <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_boundary;

      if (!enable) begin
        r_cnt <= '0;
        r_idx <= 2'd0;
      end else if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // The swap reads the old shadow, so a frame captured in the boundary
      // clock itself waits for the following boundary.
      if (w_boundary && r_pending) r_active <= r_shadow;
      if (w_boundary)              r_pending <= 1'b0;
      if (w_accept) begin
        r_shadow  <= digits;
        r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

  localparam int TD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load_valid = 1'b0;
  logic [23:0] digits = '0;
  logic        load_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_controller #(.TICK_DIV(TD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .digits     (digits),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Glyph reference built from lit-segment patterns (1 = lit), then inverted.
  function automatic logic [6:0] ref_glyph(input int code);
    logic [6:0] hi;
    case (code)
      0: hi = 7'b1111110;  1: hi = 7'b0110000;  2: hi = 7'b1101101;
      3: hi = 7'b1111001;  4: hi = 7'b0110011;  5: hi = 7'b1011011;
      6: hi = 7'b1011111;  7: hi = 7'b1110000;  8: hi = 7'b1111111;
      9: hi = 7'b1111011; 10: hi = 7'b1110111; 11: hi = 7'b0011111;
      12: hi = 7'b1001110; 13: hi = 7'b0111101; 14: hi = 7'b1001111;
      15: hi = 7'b1000111; 17: hi = 7'b0000001;
      default: hi = 7'b0000000;
    endcase
    return ~hi;
  endfunction

  // Behavioural model: position = enabled clocks since scan (re)start.
  int         m_pos;
  int         m_act[4];
  int         m_sh[4];
  bit         m_pend;
  bit         m_valid = 1'b0;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_fd;

  always @(posedge clk) begin
    int c, d;
    bit acc, bnd;
    acc = load_valid && !m_pend;
    if (!rst_n) begin
      m_pos = 0; m_pend = 0; m_valid = 1;
      for (int k = 0; k < 4; k++) begin m_act[k] = 16; m_sh[k] = 16; end
      e_an = 4'hF; e_seg = 7'h7F; e_fd = 0;
    end else begin
      if (!enable) begin
        e_an = 4'hF; e_seg = 7'h7F; e_fd = 0; m_pos = 0;
      end else begin
        c = m_pos % TD;
        d = (m_pos / TD) % 4;
        if (c < BC) begin
          e_an = 4'hF; e_seg = 7'h7F;
        end else begin
          e_an = 4'hF ^ (4'b1 << d);
          e_seg = ref_glyph(m_act[d]);
        end
        bnd = (c == TD - 1) && (d == 3);
        e_fd = bnd;
        if (bnd && m_pend) for (int k = 0; k < 4; k++) m_act[k] = m_sh[k];
        if (bnd) m_pend = 0;
        m_pos = m_pos + 1;
      end
      if (acc) begin
        for (int k = 0; k < 4; k++) m_sh[k] = int'(digits[6*k +: 6]);
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("an", {28'd0, an}, {28'd0, e_an});
      chk("seg", {25'd0, seg}, {25'd0, e_seg});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
      chk("load_ready", {31'd0, load_ready}, {31'd0, !m_pend});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_fd(input int max, output int n);
    n = 0;
    do begin step(); n++; end while (!frame_done && n < max);
    chk("fd_seen", {31'd0, frame_done}, 32'd1);
  endtask

  logic [6:0] g_exp[4];
  int         n;

  initial begin
    g_exp = '{7'b0000000, 7'b0100100, 7'b0001000, 7'b1111110};
    rst_n = 0; enable = 1;
    step(3);
    rst_n = 1;
    // idle after reset: 2 blank clocks then digit0 driven with OFF glyph
    for (int i = 0; i < 8; i++) begin
      step();
      chk("idle_an", {28'd0, an}, (i < 2) ? 32'hF : 32'hE);
      chk("idle_seg", {25'd0, seg}, 32'h7F);
      chk("idle_ready", {31'd0, load_ready}, 32'd1);
    end

    // load {17,10,5,8} and scan it
    digits = {6'd17, 6'd10, 6'd5, 6'd8}; load_valid = 1;
    step(); load_valid = 0;
    chk("ready_after_load", {31'd0, load_ready}, 32'd0);
    wait_fd(100, n);
    step(3);
    for (int k = 0; k < 4; k++) begin
      chk("scan_seg", {25'd0, seg}, {25'd0, g_exp[k]});
      chk("scan_an", {28'd0, an}, {28'd0, 4'hF ^ (4'b1 << k)});
      step(8);
    end
    wait_fd(100, n);
    wait_fd(100, n);
    chk("fd_period", n, 32'd32);

    // anti-tear: second load mid-frame, third refused while pending
    step(10);
    digits = {6'd0, 6'd1, 6'd2, 6'd3}; load_valid = 1;
    step();
    chk("ready_pending", {31'd0, load_ready}, 32'd0);
    digits = {6'd9, 6'd9, 6'd9, 6'd9};
    step(); load_valid = 0;
    chk("ready_third", {31'd0, load_ready}, 32'd0);
    step(8);
    chk("old_digit2", {25'd0, seg}, 32'h08);
    wait_fd(100, n);
    step(3);
    chk("new_digit0", {25'd0, seg}, 32'h06);
    step(8);
    chk("new_digit1", {25'd0, seg}, 32'h12);

    // load accepted in the boundary clock itself
    step(20);
    digits = {6'd15, 6'd14, 6'd13, 6'd12}; load_valid = 1;
    step(); load_valid = 0;
    chk("bnd_fd", {31'd0, frame_done}, 32'd1);
    chk("bnd_ready", {31'd0, load_ready}, 32'd0);
    step(3);
    chk("bnd_keep_d0", {25'd0, seg}, 32'h06);
    wait_fd(100, n);
    step(3);
    chk("bnd_new_d0", {25'd0, seg}, 32'h31);

    // enable drop in a digit2 drive slot, load while disabled
    step(17);
    enable = 0;
    step();
    chk("dis_an", {28'd0, an}, 32'hF);
    chk("dis_seg", {25'd0, seg}, 32'h7F);
    digits = {6'd1, 6'd2, 6'd3, 6'd4}; load_valid = 1;
    step(); load_valid = 0;
    step(5);
    chk("dis_pending", {31'd0, load_ready}, 32'd0);
    enable = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reen_an", {28'd0, an}, (i < 2) ? 32'hF : 32'hE);
    end

    // reset one clock before the boundary with a frame pending
    wait_fd(100, n);
    step(4);
    digits = {6'd8, 6'd8, 6'd8, 6'd8}; load_valid = 1;
    step(); load_valid = 0;
    chk("rst_pend_ready", {31'd0, load_ready}, 32'd0);
    step(25);
    rst_n = 0; load_valid = 1;
    step(2);
    rst_n = 1; load_valid = 0;
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("rst_off_seg", {25'd0, seg}, 32'h7F);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 1499) != 0);
      load_valid = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < 4; k++)
        digits[6*k +: 6] = ($urandom_range(0, 9) < 6) ? 6'($urandom_range(0, 17))
                                                      : 6'($urandom_range(0, 63));
      if (enable && $urandom_range(0, 299) == 0) enable = 0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1;
      step();
    end
    rst_n = 1; load_valid = 0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
